// File: rtl/nic_access_ctrl.sv
// Blocking NIC register-port sequencer for MEM-stage loads and stores.
// Polls NIC status until the channel is ready, stalls the pipeline, and returns load data.
module nic_access_ctrl #(
  parameter int DATA_W     = 64,
  parameter int POLL_LIMIT = 255,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              nic_req,
  input  logic              nic_req_wr,
  input  logic [1:0]        nic_req_addr,
  input  logic [4:0]        nic_req_rd,
  input  logic [DATA_W-1:0] nic_req_data,
  output logic              stall,
  output logic              nic_en,
  output logic              nic_wr_en,
  output logic [1:0]        nic_addr,
  output logic [DATA_W-1:0] nic_din,
  input  logic [DATA_W-1:0] nic_dout,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              nic_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POLL_REQ = 3'd1,
    S_POLL_CHK = 3'd2,
    S_ACCESS   = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [1:0]          r_addr;
  logic [4:0]          r_rd;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_abort;
  logic                r_ill;
  logic                w_legal;
  logic                w_poll;
  logic                w_accept;
  logic                w_met;
  logic                w_limit;
  logic [CNT_W-1:0]    w_cnt_nx;

  // Request legality and whether it must wait on the status register
  always_comb begin
    w_legal = 1'b0;
    w_poll  = 1'b0;
    case ({nic_req_wr, nic_req_addr})
      3'b001: begin
        w_legal = 1'b1;
        w_poll  = 1'b1;
      end
      3'b010, 3'b011: begin
        w_legal = 1'b1;
        w_poll  = 1'b0;
      end
      3'b110: begin
        w_legal = 1'b1;
        w_poll  = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
        w_poll  = 1'b0;
      end
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && nic_req && w_legal;
  // Loads wait for input channel full; stores wait for output channel not full.
  assign w_met    = r_wr ? ~nic_dout[1] : nic_dout[0];
  assign w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_limit  = (POLL_LIMIT != 0) && (w_cnt_nx == CNT_W'(POLL_LIMIT));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_poll ? S_POLL_REQ : S_ACCESS;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_POLL_REQ: w_next = S_POLL_CHK;
      S_POLL_CHK: begin
        if (w_met) begin
          w_next = S_ACCESS;
        end else if (w_limit) begin
          w_next = S_RESP;
        end else begin
          w_next = S_POLL_REQ;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latches, poll counter, abort and illegal-request flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= 1'b0;
      r_addr  <= 2'b00;
      r_rd    <= 5'd0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_ill <= (r_state == S_IDLE) && nic_req && !w_legal;
      if (w_accept) begin
        r_wr    <= nic_req_wr;
        r_addr  <= nic_req_addr;
        r_rd    <= nic_req_rd;
        r_data  <= nic_req_wr ? nic_req_data : '0;
        r_cnt   <= '0;
        r_abort <= 1'b0;
      end else if ((r_state == S_POLL_CHK) && !w_met) begin
        if (w_limit) begin
          r_abort <= 1'b1;
        end else begin
          r_cnt <= w_cnt_nx;
        end
      end
    end
  end

  // Output decode; only one NIC enable source is active in any state
  always_comb begin
    stall     = ((r_state != S_IDLE) && (r_state != S_RESP)) || w_accept;
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = 2'b00;
    nic_din   = '0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = '0;
    nic_err   = r_ill;
    case (r_state)
      S_POLL_REQ: begin
        nic_en   = 1'b1;
        nic_addr = 2'b11;
      end
      S_ACCESS: begin
        nic_en    = 1'b1;
        nic_wr_en = r_wr;
        nic_addr  = r_addr;
        nic_din   = r_data;
      end
      S_RESP: begin
        if (r_abort) begin
          nic_err = 1'b1;
        end else if (!r_wr) begin
          wb_valid = 1'b1;
          wb_rd    = r_rd;
          wb_data  = nic_dout;
        end else begin
          wb_valid = 1'b0;
        end
      end
      default: begin
        nic_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nic_access_ctrl.sv
// Directed bench for nic_access_ctrl with a small behavioural NIC register model.
module tb_nic_access_ctrl;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          nic_req = 1'b0;
  logic          nic_req_wr = 1'b0;
  logic [1:0]    nic_req_addr = 2'b00;
  logic [4:0]    nic_req_rd = 5'd0;
  logic [DW-1:0] nic_req_data = '0;
  logic          stall, nic_en, nic_wr_en, wb_valid, nic_err;
  logic [1:0]    nic_addr;
  logic [DW-1:0] nic_din, wb_data;
  logic [DW-1:0] nic_dout = '0;
  logic [4:0]    wb_rd;

  int n_checks = 0;
  int n_errors = 0;

  // NIC model state
  int            stat_cnt = 0, in_rd_cnt = 0, out_rd_cnt = 0, wr_cnt = 0;
  int            in_fail = 1000;
  logic          out_full = 1'b0;
  logic [DW-1:0] in_buf = '0, out_buf = '0, last_wr_data = '0;
  logic [1:0]    last_wr_addr = 2'b00;

  nic_access_ctrl #(.DATA_W(DW), .POLL_LIMIT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .nic_req(nic_req), .nic_req_wr(nic_req_wr),
    .nic_req_addr(nic_req_addr), .nic_req_rd(nic_req_rd), .nic_req_data(nic_req_data),
    .stall(stall), .nic_en(nic_en), .nic_wr_en(nic_wr_en), .nic_addr(nic_addr),
    .nic_din(nic_din), .nic_dout(nic_dout), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .nic_err(nic_err)
  );

  always #5 clk = ~clk;

  // NIC register port: read data appears the cycle after the enable
  always @(posedge clk) begin
    if (nic_en && nic_wr_en) begin
      wr_cnt++;
      last_wr_addr = nic_addr;
      last_wr_data = nic_din;
    end else if (nic_en) begin
      case (nic_addr)
        2'b11: begin
          nic_dout <= {{(DW-2){1'b0}}, out_full, (stat_cnt >= in_fail)};
          stat_cnt++;
        end
        2'b01: begin nic_dout <= in_buf;  in_rd_cnt++;  end
        2'b10: begin nic_dout <= out_buf; out_rd_cnt++; end
        default: nic_dout <= '0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    stat_cnt = 0; in_rd_cnt = 0; out_rd_cnt = 0; wr_cnt = 0;
  endtask

  // Issue one request; holds it while stalled and through RESP, like the pipeline would.
  task automatic do_req(input logic wr, input logic [1:0] addr, input logic [4:0] rd,
                        input logic [DW-1:0] data, output int n_stall,
                        output logic v, output logic [4:0] rd_o, output logic [DW-1:0] d_o,
                        output logic err_o, output logic err_nx);
    nic_req = 1'b1; nic_req_wr = wr; nic_req_addr = addr; nic_req_rd = rd; nic_req_data = data;
    #1;
    n_stall = 0;
    while (stall && n_stall < 50) begin
      n_stall++;
      @(negedge clk); #1;
    end
    v = wb_valid; rd_o = wb_rd; d_o = wb_data; err_o = nic_err;
    @(negedge clk);
    nic_req = 1'b0;
    #1;
    err_nx = nic_err;
  endtask

  int            ns;
  logic          v, e0, e1;
  logic [4:0]    rdo;
  logic [DW-1:0] dout;
  int            stat_before;

  initial begin
    // Reset state
    #2;
    check("reset_outputs", {56'd0, stall, nic_en, nic_wr_en, nic_addr, wb_valid, nic_err, 1'b0}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Load 11: no polling, status value returned
    clear_counts(); in_fail = 1000; out_full = 1'b1;
    do_req(1'b0, 2'b11, 5'd7, 64'd0, ns, v, rdo, dout, e0, e1);
    check("ld11_stall", 64'(ns), 64'd2);
    check("ld11_valid", {63'd0, v}, 64'd1);
    check("ld11_rd", {59'd0, rdo}, 64'd7);
    check("ld11_data", dout, 64'h2);
    check("ld11_stat_rds", 64'(stat_cnt), 64'd1);

    // Load 01: three failed checks then data ready
    clear_counts(); in_fail = 3; out_full = 1'b0; in_buf = 64'hDEADBEEF;
    do_req(1'b0, 2'b01, 5'd12, 64'd0, ns, v, rdo, dout, e0, e1);
    check("ld01_stall", 64'(ns), 64'd10);
    check("ld01_stat_rds", 64'(stat_cnt), 64'd4);
    check("ld01_in_rds", 64'(in_rd_cnt), 64'd1);
    check("ld01_valid_rd", {58'd0, v, rdo}, {58'd0, 1'b1, 5'd12});
    check("ld01_data", dout, 64'hDEADBEEF);
    check("ld01_err", {62'd0, e0, e1}, 64'd0);

    // Store 10 timeout with output channel always full
    clear_counts(); out_full = 1'b1;
    do_req(1'b1, 2'b10, 5'd3, 64'h1234, ns, v, rdo, dout, e0, e1);
    check("st_to_stall", 64'(ns), 64'd9);
    check("st_to_stat_rds", 64'(stat_cnt), 64'd4);
    check("st_to_writes", 64'(wr_cnt), 64'd0);
    check("st_to_valid", {63'd0, v}, 64'd0);
    check("st_to_err_pulse", {62'd0, e0, e1}, 64'b10);

    // Illegal store 01
    clear_counts(); out_full = 1'b0;
    @(negedge clk);
    do_req(1'b1, 2'b01, 5'd0, 64'h55, ns, v, rdo, dout, e0, e1);
    check("ill_stall", 64'(ns), 64'd0);
    check("ill_err_next", {62'd0, e0, e1}, 64'b01);
    @(negedge clk); #1;
    check("ill_err_one_cycle", {63'd0, nic_err}, 64'd0);
    check("ill_no_access", 64'(stat_cnt + in_rd_cnt + out_rd_cnt + wr_cnt), 64'd0);

    // Load 10 followed immediately by store 10
    clear_counts(); out_buf = 64'h55AA_F00D;
    @(negedge clk);
    do_req(1'b0, 2'b10, 5'd9, 64'd0, ns, v, rdo, dout, e0, e1);
    check("b2b_ld_stall", 64'(ns), 64'd2);
    check("b2b_ld_data", dout, 64'h55AA_F00D);
    do_req(1'b1, 2'b10, 5'd0, 64'hCAFE_1234, ns, v, rdo, dout, e0, e1);
    check("b2b_st_stall", 64'(ns), 64'd4);
    check("b2b_st_writes", 64'(wr_cnt), 64'd1);
    check("b2b_st_wdata", last_wr_data, 64'hCAFE_1234);
    check("b2b_st_waddr", {62'd0, last_wr_addr}, 64'd2);
    check("b2b_st_valid", {63'd0, v}, 64'd0);

    // Reset during POLL_CHK with the input channel empty
    clear_counts(); in_fail = 1000;
    @(negedge clk);
    nic_req = 1'b1; nic_req_wr = 1'b0; nic_req_addr = 2'b01; nic_req_rd = 5'd4;
    @(negedge clk);
    @(negedge clk);
    #1;
    nic_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {56'd0, stall, nic_en, nic_wr_en, nic_addr, wb_valid, nic_err, 1'b0}, 64'd0);
    check("rst_mid_din_wb", nic_din | wb_data | {59'd0, wb_rd}, 64'd0);
    stat_before = stat_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_idle_stall", {63'd0, stall}, 64'd0);
    check("rst_idle_no_poll", 64'(stat_cnt - stat_before), 64'd0);
    check("rst_idle_no_write", 64'(wr_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
